m_cyclecnt_p: RTL and testbench



---
 rtl/m_cyclecnt_p.sv | 191 +++++++++++++++++++
 tb/tb_m_cyclecnt_p.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/m_cyclecnt_p.sv
// m_cyclecnt_p -- per-instruction cycle timer for the midgetv core.
//
// Purpose:
//   Counts the cycles of each instruction in a CW-bit saturating counter
//   (rccnt). At an instruction boundary (sa16) the count is presented on
//   the ALU B operand so it can be added to the 64-bit time register. When
//   sa16 is low, QQ carries the PC, or the PC with its two low bits forced
//   to 1 (the +3/+4 increment constant). The block also holds the core
//   until start has been high for STARTCNT consecutive cycles. It reports
//   an instruction that runs for TIMEOUT cycles or longer as a bus error.
//
// Parameters:
//   CW       counter width, 3..16
//   TIMEOUT  instruction length (cycles) that raises a bus error, 2..2^CW-1
//   STARTCNT consecutive start-high cycles needed to release the core,
//            1..65535
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   sa17         in   QQ select when sa16=0: 1 -> ADR_O, 0 -> ADR_O|3
//   sa16         in   instruction boundary: rccnt onto QQ, counter reload
//   ADR_O[31:0]  in   address / PC value
//   start        in   external enable, must stay high to release the core
//   QQ[31:0]     out  ALU B operand
//   corerunning  out  core released (sticky until rst)
//   nobuserror   out  low on timeout or during/just after reset
//   hwm[CW-1:0]  out  longest instruction length seen
//
// Optional feature:
//   Define M_CYCLECNT_HWM_EN to build the high-water-mark register. When it
//   is not defined, hwm is tied to zero.

module m_cyclecnt_p #(
  parameter int CW       = 6,
  parameter int TIMEOUT  = 63,
  parameter int STARTCNT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sa17,
  input  logic          sa16,
  input  logic [31:0]   ADR_O,
  input  logic          start,
  output logic [31:0]   QQ,
  output logic          corerunning,
  output logic          nobuserror,
  output logic [CW-1:0] hwm
);

  // Elaboration-time parameter range checks
  if (CW < 3 || CW > 16) begin : g_bad_cw
    $error("m_cyclecnt_p: CW must be in 3..16");
  end
  if (TIMEOUT < 2 || TIMEOUT > ((1 << CW) - 1)) begin : g_bad_timeout
    $error("m_cyclecnt_p: TIMEOUT must be in 2..2^CW-1");
  end
  if (STARTCNT < 1 || STARTCNT > 65535) begin : g_bad_startcnt
    $error("m_cyclecnt_p: STARTCNT must be in 1..65535");
  end

  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
  localparam logic [15:0]   ARM_LAST   = 16'(STARTCNT - 1);
  localparam bit            DIRECT_RUN = (STARTCNT == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } st_t;

  st_t            st_q, st_d;
  logic [15:0]    armcnt_q, armcnt_d;
  logic [CW-1:0]  rccnt_q, rccnt_d;
  logic           veryfirst_q;
  logic           run;
  logic           timeout;

  // Saturating increment: the counter sticks at all-ones, never wraps, so
  // a runaway instruction keeps reporting a timeout.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  assign run = (st_q == RUN);

  // Start qualification: start must be high for STARTCNT consecutive
  // cycles; any low cycle while arming drops back to IDLE.
  always_comb begin
    st_d     = st_q;
    armcnt_d = armcnt_q;
    case (st_q)
      IDLE: begin
        if (start) begin
          if (DIRECT_RUN) begin
            st_d = RUN;
          end else begin
            st_d     = ARM;
            armcnt_d = 16'd1;
          end
        end
      end
      ARM: begin
        if (!start) begin
          st_d     = IDLE;
          armcnt_d = '0;
        end else if (armcnt_q == ARM_LAST) begin
          st_d = RUN;
        end else begin
          armcnt_d = armcnt_q + 16'd1;
        end
      end
      RUN: begin
        st_d = RUN;
      end
      default: begin
        st_d     = IDLE;
        armcnt_d = '0;
      end
    endcase
  end

  always_comb begin
    rccnt_d = rccnt_q;
    if (!run || sa16) begin
      rccnt_d = CNT_ONE;
    end else begin
      rccnt_d = sat_inc(rccnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= IDLE;
      armcnt_q    <= '0;
      rccnt_q     <= CNT_ONE;
      veryfirst_q <= 1'b1;
    end else begin
      st_q        <= st_d;
      armcnt_q    <= armcnt_d;
      rccnt_q     <= rccnt_d;
      veryfirst_q <= 1'b0;
    end
  end

  assign corerunning = run;

  // A boundary in the same cycle clears the timeout. rst is ORed in so
  // the error is visible during the first reset cycle, before the flag
  // has been loaded.
  assign timeout    = run && !sa16 && (rccnt_q >= TIMEOUT_C);
  assign nobuserror = ~(timeout | veryfirst_q | rst);

  always_comb begin
    QQ = ADR_O | 32'h0000_0003;
    if (sa16) begin
      QQ = {ADR_O[31:CW], rccnt_q};
    end else if (sa17) begin
      QQ = ADR_O;
    end
  end

`ifdef M_CYCLECNT_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (run && sa16 && (rccnt_q > hwm_q)) begin
      hwm_d = rccnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_m_cyclecnt_p.sv
module tb_m_cyclecnt_p;

  localparam int CW       = 6;
  localparam int TIMEOUT  = 10;
  localparam int STARTCNT = 64;
  localparam int MAXC     = (1 << CW) - 1;
`ifdef M_CYCLECNT_HWM_EN
  localparam bit HWM_ON = 1'b1;
`else
  localparam bit HWM_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, sa17, sa16, start;
  logic [31:0]   ADR_O;
  logic [31:0]   QQ;
  logic          corerunning, nobuserror;
  logic [CW-1:0] hwm;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Behavioural model of the timer
  bit m_run;
  bit m_vf;
  int m_streak;
  int m_len;
  int m_hwm;

  m_cyclecnt_p #(.CW(CW), .TIMEOUT(TIMEOUT), .STARTCNT(STARTCNT)) dut (
    .clk(clk), .rst(rst), .sa17(sa17), .sa16(sa16), .ADR_O(ADR_O),
    .start(start), .QQ(QQ), .corerunning(corerunning),
    .nobuserror(nobuserror), .hwm(hwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, got, exp);
    end
  endtask

  // Model update: the core is released after STARTCNT consecutive start-high
  // cycles; instruction length counts cycles since the last boundary,
  // saturating at 2^CW-1; the high-water mark keeps the longest length.
  always @(posedge clk) begin
    if (rst) begin
      m_run    <= 1'b0;
      m_vf     <= 1'b1;
      m_streak <= 0;
      m_len    <= 1;
      m_hwm    <= 0;
    end else begin
      m_vf <= 1'b0;
      if (!m_run) begin
        m_len <= 1;
        if (start) begin
          m_streak <= m_streak + 1;
          if (m_streak + 1 >= STARTCNT) m_run <= 1'b1;
        end else begin
          m_streak <= 0;
        end
      end else if (sa16) begin
        m_len <= 1;
        if (m_len > m_hwm) m_hwm <= m_len;
      end else begin
        m_len <= (m_len + 1 > MAXC) ? MAXC : m_len + 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin : cmp
      logic [31:0] e_qq;
      bit          e_nbe;
      if (sa16)      e_qq = (ADR_O & ~32'(MAXC)) | 32'(m_len);
      else if (sa17) e_qq = ADR_O;
      else           e_qq = ADR_O | 32'h3;
      e_nbe = !(rst || m_vf || (m_run && !sa16 && m_len >= TIMEOUT));
      chk("cyc_qq", QQ, e_qq);
      chk("cyc_corerunning", {31'd0, corerunning}, {31'd0, m_run});
      chk("cyc_nobuserror", {31'd0, nobuserror}, {31'd0, e_nbe});
      chk("cyc_hwm", 32'(hwm), HWM_ON ? 32'(m_hwm) : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sa16 = 1'b0; sa17 = 1'b1; ADR_O = 32'd0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    step(); step();
    #1;
    chk("rst_corerunning", 32'(corerunning), 32'd0);
    chk("rst_nobuserror", 32'(nobuserror), 32'd0);
    chk("rst_hwm", 32'(hwm), 32'd0);
    rst = 1'b0;
    #1 chk("veryfirst_low", 32'(nobuserror), 32'd0);
    step();
    #1 chk("veryfirst_over", 32'(nobuserror), 32'd1);

    // Arming: 63-cycle window is too short, then a full 64-cycle window
    start = 1'b1;
    repeat (63) step();
    start = 1'b0;
    #1 chk("arm63_still_idle", 32'(corerunning), 32'd0);
    step();
    start = 1'b1;
    repeat (63) step();
    #1 chk("arm_before_64", 32'(corerunning), 32'd0);
    step();
    #1 chk("armed_64", 32'(corerunning), 32'd1);

    // Counting and mux
    sa16 = 1'b0; sa17 = 1'b1;
    repeat (5) step();
    sa16 = 1'b1; ADR_O = 32'hABCD_EF40;
    #1 chk("qq_count6", QQ, 32'hABCD_EF46);
    step();
    #1 chk("qq_reload1", QQ, 32'hABCD_EF41);

    // +3 path and pass-through
    sa16 = 1'b0; sa17 = 1'b0; ADR_O = 32'h0000_1004;
    #1 chk("qq_plus3", QQ, 32'h0000_1007);
    sa17 = 1'b1;
    #1 chk("qq_pass", QQ, 32'h0000_1004);

    // Timeout, saturation, boundary release
    repeat (8) step();
    #1 chk("timeout_len9", 32'(nobuserror), 32'd1);
    step();
    #1 chk("timeout_len10", 32'(nobuserror), 32'd0);
    repeat (60) step();
    #1 chk("timeout_held", 32'(nobuserror), 32'd0);
    ADR_O = 32'd0; sa16 = 1'b1;
    #1 chk("saturate_qq", QQ, 32'h0000_003F);
    chk("boundary_release", 32'(nobuserror), 32'd1);
    step();

    // Reset mid-instruction with start held high
    sa16 = 1'b0;
    repeat (19) step();
    sa16 = 1'b1;
    #1 chk("mid_len20", QQ, 32'd20);
    sa16 = 1'b0;
    rst = 1'b1;
    #1 chk("midrst_nobuserror", 32'(nobuserror), 32'd0);
    step();
    rst = 1'b0;
    #1 chk("midrst_corerunning", 32'(corerunning), 32'd0);
    chk("midrst_after_nbe", 32'(nobuserror), 32'd0);
    sa16 = 1'b1;
    #1 chk("midrst_rccnt", QQ, 32'd1);
    sa16 = 1'b0;
    step();
    #1 chk("midrst_nbe_back", 32'(nobuserror), 32'd1);
    repeat (62) step();
    #1 chk("rearm_before_64", 32'(corerunning), 32'd0);
    step();
    #1 chk("rearm_64", 32'(corerunning), 32'd1);

    // High-water mark: lengths 4, 9, 3
    repeat (3) step();
    sa16 = 1'b1;
    step();
    sa16 = 1'b0;
    #1 chk("hwm_after4", 32'(hwm), HWM_ON ? 32'd4 : 32'd0);
    repeat (8) step();
    sa16 = 1'b1;
    step();
    sa16 = 1'b0;
    #1 chk("hwm_after9", 32'(hwm), HWM_ON ? 32'd9 : 32'd0);
    repeat (2) step();
    sa16 = 1'b1;
    step();
    sa16 = 1'b0;
    #1 chk("hwm_after3", 32'(hwm), HWM_ON ? 32'd9 : 32'd0);

    // Randomized traffic against the model
    repeat (2000) begin
      step();
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 99) != 0);
      sa16  = ($urandom_range(0, 7) == 0);
      sa17  = 1'($urandom_range(0, 1));
      ADR_O = $urandom;
    end
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
